seq_tx: RTL and testbench

Serial pattern transmitter: the sending end of the serial pattern-detect link. On a start request it emits framed copies of a fixed bit pattern on a single-bit line. Each frame is a run of idle zeros followed by the pattern, MSB first. The default frame is 2 idle cycles then `10010`, which keeps a free-running 7-cycle detector (1 ignored cycle, 5 checked bits, 1 output cycle) aligned across back-to-back frames. It sits in front of the detector in loopback benches and drives the board-level serial test line.

---
 rtl/seq_tx_if.sv | 21 ++
 rtl/seq_tx.sv | 130 +++++++++++++
 tb/tb_seq_tx.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/seq_tx_if.sv
// Serial pattern transmitter link bundle: request/control inputs and the
// registered serial line plus status flags.
interface seq_tx_if;
    logic       start;
    logic [3:0] rep_num;
    logic       abort;
    logic       dout;
    logic       dout_en;
    logic       busy;
    logic       done;

    modport master (
        output start, rep_num, abort,
        input  dout, dout_en, busy, done
    );

    modport slave (
        input  start, rep_num, abort,
        output dout, dout_en, busy, done
    );
endinterface

// File: rtl/seq_tx.sv
// Serial pattern transmitter: emits rep_num framed copies of PATTERN, each
// frame being GAP idle zeros followed by the pattern MSB first.
module seq_tx #(
    parameter int unsigned        PAT_LEN = 5,
    parameter logic [PAT_LEN-1:0] PATTERN = 5'b10010,
    parameter int unsigned        GAP     = 2
) (
    input logic     clk,
    input logic     rst_n,
    seq_tx_if.slave bus
);
    localparam logic [3:0] GAP_LAST = 4'(GAP - 1);
    localparam logic [3:0] BIT_LAST = 4'(PAT_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LEAD = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] gap_q, gap_d;
    logic [3:0] bit_q, bit_d;
    logic [3:0] frames_q, frames_d;
    logic [3:0] frames_rem;
    logic       accept;
    logic       last_bit;

    logic dout_q, dout_d;
    logic dout_en_q, dout_en_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gap_q     <= '0;
            bit_q     <= '0;
            frames_q  <= '0;
            dout_q    <= 1'b0;
            dout_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            bit_q     <= bit_d;
            frames_q  <= frames_d;
            dout_q    <= dout_d;
            dout_en_q <= dout_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        bit_d      = bit_q;
        frames_d   = frames_q;
        accept     = 1'b0;
        last_bit   = (bit_q == BIT_LAST);
        frames_rem = frames_q - 4'(frames_q != 4'd0);

        case (state_q)
            IDLE: accept = bus.start && !bus.abort;
            LEAD: begin
                if (gap_q == GAP_LAST) begin
                    state_d = SEND;
                    bit_d   = '0;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            SEND: begin
                if (last_bit) begin
                    if (frames_rem != 4'd0) begin
                        state_d  = LEAD;
                        gap_d    = '0;
                        bit_d    = '0;
                        frames_d = frames_rem;
                    end else begin
                        // The completion edge already counts as IDLE, so a held
                        // start chains the next run without a dead cycle.
                        state_d  = IDLE;
                        frames_d = '0;
                        accept   = bus.start;
                    end
                end else begin
                    bit_d = bit_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            state_d  = LEAD;
            gap_d    = '0;
            bit_d    = '0;
            frames_d = (bus.rep_num == 4'd0) ? 4'd1 : bus.rep_num;
        end

        if (bus.abort && (state_q != IDLE)) begin
            state_d  = IDLE;
            gap_d    = '0;
            bit_d    = '0;
            frames_d = '0;
        end
    end

    // Outputs are derived from the next state so they land in registers.
    always_comb begin
        dout_d    = 1'b0;
        dout_en_d = (state_d == SEND);
        busy_d    = (state_d != IDLE);
        done_d    = (state_q == SEND) && last_bit && (frames_rem == 4'd0) && !bus.abort;
        if (state_d == SEND) begin
            for (int i = 0; i < int'(PAT_LEN); i++) begin
                if ((BIT_LAST - bit_d) == 4'(i)) begin
                    dout_d = PATTERN[i];
                end
            end
        end
    end

    assign bus.dout    = dout_q;
    assign bus.dout_en = dout_en_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_seq_tx.sv
// Scoreboard bench for seq_tx: a frame-level reference model queues the
// expected outputs per edge and a monitor compares them after each edge.
module tb_seq_tx;
    localparam int         PAT_LEN = 5;
    localparam logic [4:0] PATTERN = 5'b10010;
    localparam int         GAP     = 2;

    typedef struct packed {
        logic dout;
        logic dout_en;
        logic busy;
        logic done;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_tx_if bus();

    seq_tx #(
        .PAT_LEN(PAT_LEN),
        .PATTERN(PATTERN),
        .GAP    (GAP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];
    exp_t plan[$];
    logic prev_busy = 1'b0;

    function automatic logic [3:0] outs();
        return {bus.dout, bus.dout_en, bus.busy, bus.done};
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: dout/en/busy/done got %b expected %b at %0t", name, act, expv, $time);
        end
    endtask

    // Reference model: a run of N frames is a list of N*(GAP+PAT_LEN) busy
    // cycles followed by one done cycle; the model plays that list back.
    task automatic model_step(input logic st, input logic [3:0] rep, input logic ab);
        exp_t e;
        logic completing;
        int   n;
        completing = (plan.size() > 0) && plan[0].done;
        e = '0;
        if (ab && prev_busy) begin
            plan.delete();
        end else if (st && (prev_busy ? completing : !ab)) begin
            n = (rep == 4'd0) ? 1 : int'(rep);
            plan.delete();
            for (int f = 0; f < n; f++) begin
                for (int t = 0; t < GAP + PAT_LEN; t++) begin
                    exp_t x;
                    x.busy    = 1'b1;
                    x.done    = 1'b0;
                    x.dout_en = (t >= GAP);
                    x.dout    = (t >= GAP) ? PATTERN[PAT_LEN - 1 - (t - GAP)] : 1'b0;
                    plan.push_back(x);
                end
            end
            e.done = 1'b1;
            plan.push_back(e);
            e = plan.pop_front();
            e.done = completing;
        end else if (plan.size() > 0) begin
            e = plan.pop_front();
        end
        prev_busy = e.busy;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic st, input logic [3:0] rep, input logic ab);
        @(negedge clk);
        bus.start   = st;
        bus.rep_num = rep;
        bus.abort   = ab;
        model_step(st, rep, ab);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("cycle", outs(), e);
        end
    end

    initial begin
        bus.start   = 1'b0;
        bus.rep_num = 4'd0;
        bus.abort   = 1'b0;
        #1;
        check("reset_state", outs(), 4'b0000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        repeat (20) step(1'b0, 4'd0, 1'b0);

        step(1'b1, 4'd1, 1'b0);
        repeat (10) step(1'b0, 4'd1, 1'b0);
        step(1'b1, 4'd0, 1'b0);
        repeat (10) step(1'b0, 4'd0, 1'b0);
        step(1'b1, 4'd3, 1'b0);
        repeat (25) step(1'b0, 4'd3, 1'b0);

        // start pulses and rep_num changes while busy
        step(1'b1, 4'd2, 1'b0);
        for (int i = 0; i < 18; i++) step((i % 3) == 0, 4'(i), 1'b0);
        repeat (4) step(1'b0, 4'd0, 1'b0);

        // abort sampled while the third pattern bit is on the line
        step(1'b1, 4'd2, 1'b0);
        repeat (4) step(1'b0, 4'd0, 1'b0);
        step(1'b0, 4'd0, 1'b1);
        repeat (4) step(1'b0, 4'd0, 1'b0);
        step(1'b1, 4'd1, 1'b0);
        repeat (10) step(1'b0, 4'd0, 1'b0);

        // abort with start in idle, abort at the completion edge
        step(1'b1, 4'd1, 1'b1);
        repeat (3) step(1'b0, 4'd0, 1'b0);
        step(1'b1, 4'd1, 1'b0);
        repeat (6) step(1'b0, 4'd0, 1'b0);
        step(1'b1, 4'd1, 1'b1);
        repeat (4) step(1'b0, 4'd0, 1'b0);

        // start held: back-to-back runs with done/busy overlap
        repeat (30) step(1'b1, 4'd1, 1'b0);
        repeat (10) step(1'b0, 4'd0, 1'b0);

        // asynchronous reset in the middle of SEND
        step(1'b1, 4'd2, 1'b0);
        repeat (3) step(1'b0, 4'd0, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", outs(), 4'b0000);
        @(posedge clk);
        #1;
        check("reset_hold", outs(), 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        plan.delete();
        prev_busy = 1'b0;
        repeat (5) step(1'b0, 4'd0, 1'b0);

        for (int i = 0; i < 2500; i++) begin
            logic       st;
            logic       ab;
            logic [3:0] rep;
            st  = ($urandom_range(0, 6) == 0);
            ab  = ($urandom_range(0, 60) == 0);
            rep = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            step(st, rep, ab);
        end

        repeat (120) step(1'b0, 4'd0, 1'b0);
        @(posedge clk);
        #3;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
